// File: rtl/tape_input_decoder.sv
// Cassette input demodulator: synchronise and filter the comparator level, classify
// rising-edge periods as 0/1 bits, lock on a leader and frame LSB-first bytes.
module tape_input_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 16,
  parameter int T_MIN       = 400,
  parameter int T_SPLIT     = 2000,
  parameter int T_MAX       = 8000,
  parameter int LEADER_MIN  = 64
) (
  input  logic       clk_cpu,
  input  logic       rst_n,
  input  logic       tape_input,
  input  logic       enable,
  output logic       tape_clean,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       locked,
  output logic       overrun,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEADER = 2'd1,
    SYNC   = 2'd2,
    DATA   = 2'd3
  } state_t;

  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam int LCW = $clog2(LEADER_MIN + 1);
  localparam logic [CNT_W-1:0] T_MIN_C   = CNT_W'(T_MIN);
  localparam logic [CNT_W-1:0] T_SPLIT_C = CNT_W'(T_SPLIT);
  localparam logic [CNT_W-1:0] T_MAX_C   = CNT_W'(T_MAX);
  localparam logic [LCW-1:0]   LEAD_MIN_C = LCW'(LEADER_MIN);
  localparam logic [LCW-1:0]   LEAD_SAT_C = {LCW{1'b1}};

  state_t           state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FCW-1:0]   filt_cnt;
  logic             clean_prev;
  logic [CNT_W-1:0] cnt;
  logic             bit_evt;
  logic             bit_val;
  logic             timeout_evt;
  logic [LCW-1:0]   lead_cnt;
  logic [2:0]       bit_cnt;
  logic [6:0]       shift_q;

  logic synced;
  logic edge_ok;
  logic accept;
  logic byte_done;

  assign synced    = sync_q[SYNC_STAGES-1];
  assign edge_ok   = tape_clean && !clean_prev && (cnt >= T_MIN_C);
  assign accept    = byte_valid && byte_ready;
  assign byte_done = enable && !timeout_evt && (state == DATA) && bit_evt && (bit_cnt == 3'd7);
  assign dbg_state = state;

  // Front end: synchroniser, run-length filter and period counter.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      filt_cnt    <= '0;
      tape_clean  <= 1'b0;
      clean_prev  <= 1'b0;
      cnt         <= '0;
      bit_evt     <= 1'b0;
      bit_val     <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], tape_input};
      clean_prev <= tape_clean;
      if (synced != tape_clean) begin
        if (filt_cnt == FCW'(FILT_LEN - 1)) begin
          tape_clean <= synced;
          filt_cnt   <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
      // Restart at 1 so the edge cycle itself is part of the next period.
      bit_evt     <= edge_ok;
      bit_val     <= (cnt >= T_SPLIT_C);
      timeout_evt <= !edge_ok && (cnt == T_MAX_C - 1'b1);
      if (edge_ok) begin
        cnt <= CNT_W'(1);
      end else if (cnt != T_MAX_C) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Framing FSM and output register.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lead_cnt   <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      locked     <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (accept) byte_valid <= 1'b0;
      if (byte_done) begin
        if (!byte_valid || accept) begin
          byte_data  <= {bit_val, shift_q};
          byte_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      if (!enable) begin
        state    <= IDLE;
        lead_cnt <= '0;
        locked   <= 1'b0;
        overrun  <= 1'b0;
      end else if (timeout_evt) begin
        state    <= IDLE;
        lead_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            lead_cnt <= '0;
            locked   <= 1'b0;
            state    <= LEADER;
          end
          LEADER: begin
            if (bit_evt) begin
              if (!bit_val) begin
                if (lead_cnt != LEAD_SAT_C) lead_cnt <= lead_cnt + 1'b1;
              end else if (lead_cnt >= LEAD_MIN_C) begin
                state   <= DATA;
                bit_cnt <= '0;
                locked  <= 1'b1;
              end else begin
                lead_cnt <= '0;
              end
            end
          end
          SYNC: begin
            if (bit_evt && bit_val) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            if (bit_evt) begin
              shift_q <= {bit_val, shift_q[6:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) state <= SYNC;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tape_input_decoder.sv
// Directed bench for tape_input_decoder with time constants scaled down so a full
// leader fits in a short run; received bytes are checked against an expected queue.
module tb_tape_input_decoder;

  localparam int T_MIN      = 40;
  localparam int T_SPLIT    = 200;
  localparam int T_MAX      = 800;
  localparam int LEADER_MIN = 64;
  localparam int P0         = 100;
  localparam int P1         = 300;

  logic       clk_cpu = 1'b0;
  logic       rst_n;
  logic       tape_input;
  logic       enable;
  logic       tape_clean;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       locked;
  logic       overrun;
  logic [1:0] dbg_state;

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int valid_cycles = 0;

  tape_input_decoder #(
    .SYNC_STAGES(2), .FILT_LEN(4), .CNT_W(16), .T_MIN(T_MIN),
    .T_SPLIT(T_SPLIT), .T_MAX(T_MAX), .LEADER_MIN(LEADER_MIN)
  ) dut (
    .clk_cpu(clk_cpu), .rst_n(rst_n), .tape_input(tape_input), .enable(enable),
    .tape_clean(tape_clean), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .locked(locked), .overrun(overrun), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk_cpu = ~clk_cpu;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_cpu);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    int p;
    p = b ? P1 : P0;
    tape_input = 1'b1;
    cyc(p / 2);
    tape_input = 1'b0;
    cyc(p - p / 2);
  endtask

  task automatic send_leader(input int n);
    repeat (n) send_bit(1'b0);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_bit(1'b1);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  // Zero bit carrying an extra clean rising edge 20 cycles into the period.
  task automatic send_glitch_zero();
    tape_input = 1'b1; cyc(10);
    tape_input = 1'b0; cyc(10);
    tape_input = 1'b1; cyc(40);
    tape_input = 1'b0; cyc(50);
  endtask

  // Scoreboard monitor: a transfer happens at the next rising edge.
  always @(negedge clk_cpu) begin
    if (rst_n && byte_valid) valid_cycles++;
    if (rst_n && byte_valid && byte_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_byte: got %0h expected none", byte_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (byte_data !== e) begin
          n_err++;
          $display("FAIL byte_data: got %0h expected %0h", byte_data, e);
        end
      end
    end
  end

  initial begin
    int lat;
    logic seen_high;
    rst_n = 1'b0; tape_input = 1'b0; enable = 1'b1; byte_ready = 1'b0;
    cyc(3);
    check("rst_tape_clean", {31'b0, tape_clean}, 0);
    check("rst_byte_data",  {24'b0, byte_data}, 0);
    check("rst_byte_valid", {31'b0, byte_valid}, 0);
    check("rst_locked",     {31'b0, locked}, 0);
    check("rst_overrun",    {31'b0, overrun}, 0);
    check("rst_state",      {30'b0, dbg_state}, 0);
    rst_n = 1'b1;
    cyc(2);

    // Glitch rejection
    seen_high = 1'b0;
    repeat (3) begin
      tape_input = 1'b1; cyc(3);
      tape_input = 1'b0;
      for (int i = 0; i < 10; i++) begin
        cyc(1);
        if (tape_clean) seen_high = 1'b1;
      end
    end
    check("glitch_rejected", {31'b0, seen_high}, 0);
    tape_input = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (tape_clean && lat == 0) lat = i;
    end
    check("filter_latency", lat, 6);
    tape_input = 1'b0;
    cyc(900);

    // Lock and byte with consumer always ready
    byte_ready = 1'b1;
    valid_cycles = 0;
    exp_q.push_back(8'hA5);
    send_leader(64);
    check("leader_unlocked", {31'b0, locked}, 0);
    send_byte(8'hA5);
    check("locked_after_start", {31'b0, locked}, 1);
    send_bit(1'b0);
    check("valid_one_cycle", valid_cycles, 1);
    check("lock_byte_done", exp_q.size(), 0);
    cyc(900);
    check("idle_after_gap", {31'b0, locked}, 0);

    // Short leader must not lock
    send_leader(63);
    send_bit(1'b1);
    send_bit(1'b0);
    check("short_leader_unlocked", {31'b0, locked}, 0);
    exp_q.push_back(8'h3C);
    send_leader(64);
    send_byte(8'h3C);
    send_bit(1'b0);
    check("relock_locked", {31'b0, locked}, 1);
    check("short_leader_byte_done", exp_q.size(), 0);
    cyc(900);

    // Backpressure and overrun
    byte_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_leader(64);
    send_byte(8'h11);
    send_byte(8'h22);
    send_bit(1'b0);
    check("bp_valid_held", {31'b0, byte_valid}, 1);
    check("bp_data_held",  {24'b0, byte_data}, 32'h11);
    check("bp_overrun",    {31'b0, overrun}, 1);
    byte_ready = 1'b1;
    cyc(4);
    byte_ready = 1'b0;
    check("bp_valid_cleared", {31'b0, byte_valid}, 0);
    check("bp_overrun_sticky", {31'b0, overrun}, 1);
    check("bp_one_transfer", exp_q.size(), 0);
    enable = 1'b0;
    cyc(2);
    check("overrun_cleared", {31'b0, overrun}, 0);
    check("disable_idle", {30'b0, dbg_state}, 0);
    enable = 1'b1;
    cyc(900);

    // Carrier loss mid-byte
    byte_ready = 1'b1;
    send_leader(64);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    cyc(T_MAX - P1 - 50);
    check("carrier_still_locked", {31'b0, locked}, 1);
    cyc(100);
    check("carrier_lost_unlocked", {31'b0, locked}, 0);
    cyc(50);
    send_leader(10);
    send_byte(8'h77);
    send_bit(1'b0);
    check("no_relock_short", {31'b0, locked}, 0);
    cyc(900);

    // Sub-T_MIN edge inside a zero period
    exp_q.push_back(8'h5A);
    send_leader(64);
    send_bit(1'b1);
    send_glitch_zero();
    for (int i = 1; i < 8; i++) send_bit(logic'((8'h5A >> i) & 8'h01));
    send_bit(1'b0);
    check("subtmin_locked", {31'b0, locked}, 1);
    check("subtmin_byte_done", exp_q.size(), 0);
    cyc(900);

    // Async reset mid-byte, then no byte without a fresh leader
    send_leader(64);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_locked", {31'b0, locked}, 0);
    check("arst_valid",  {31'b0, byte_valid}, 0);
    check("arst_data",   {24'b0, byte_data}, 0);
    check("arst_state",  {30'b0, dbg_state}, 0);
    cyc(3);
    rst_n = 1'b1;
    send_bit(1'b0);
    send_byte(8'h99);
    send_bit(1'b0);
    check("post_reset_unlocked", {31'b0, locked}, 0);

    cyc(20);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
